// File: rtl/exec_muldiv_seq_if.sv
// Handshake/data bundle between decode/execute and the iterative mul/div unit.
//   start  : request; funct/a/b are sampled on the edge the request is accepted
//   funct  : 00 MUL(lo) 01 MULHU(hi) 10 DIVU(quot) 11 REMU(rem)
//   a, b   : operands (multiplicand/dividend, multiplier/divisor)
//   flush  : abort any in-flight operation
//   stall  : freeze upstream pipeline registers
//   done   : one-cycle pulse, result valid
//   result : selected result, held until the next accepted operation
//   dz_err : pulses with done for DIVU/REMU with b==0
// Handshake: a request is accepted on a rising edge where start=1, flush=0 and
// the unit is IDLE or DONE. While an op runs, stall=1 and the requester holds
// start high; start seen during RUN is ignored. The completion is signalled by
// exactly one done pulse; there is no ready/back-pressure on the result side.
interface exec_muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             dz_err;

  modport master (
    output start, funct, a, b, flush,
    input  stall, done, result, dz_err
  );

  modport slave (
    input  start, funct, a, b, flush,
    output stall, done, result, dz_err
  );
endinterface

// File: rtl/exec_muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer sitting beside the execute stage.
// One bit per cycle: shift-add multiply or restoring divide, WIDTH iterations.
// Ports:
//   clk       : clock, all state updates on posedge
//   rst       : asynchronous active-high reset
//   bus       : exec_muldiv_seq_if slave (start/funct/a/b/flush in,
//               stall/done/result/dz_err out)
//   fsm_state : current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
module exec_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  exec_muldiv_seq_if.slave       bus,
  output logic [1:0]             fsm_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op;
  // acc: upper product half (MUL) or partial remainder (DIV).
  // lo : multiplier shifting out / product low half shifting in (MUL),
  //      dividend shifting out / quotient shifting in (DIV).
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opr;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Nothing is taken while reset or flush is asserted.
  assign accept = bus.start && !bus.flush && !rst && (state == IDLE || state == DONE);
  assign bus.stall = (bus.start && state != RUN && accept) || state == RUN;
  assign last = (cnt == CW'(WIDTH - 1));

  assign bus.done   = done_q;
  assign bus.dz_err = dz_q;
  assign bus.result = result_q;
  assign fsm_state  = state;

  always_comb begin
    mul_sum   = {1'b0, acc[WIDTH-1:0]} + (lo[0] ? {1'b0, opr} : '0);
    div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
    // Top bit of the difference is the borrow of the trial subtract.
    div_diff  = {1'b0, div_shift} - {2'b00, opr};
    acc_nxt   = acc;
    lo_nxt    = lo;
    if (!op[1]) begin
      // Product shifts right: the carry-out of the add enters the top of acc,
      // the LSB of the new upper half moves into the top of lo.
      acc_nxt = {1'b0, mul_sum[WIDTH:1]};
      lo_nxt  = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      acc_nxt = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
      lo_nxt  = {lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
    end
    case (op)
      2'b00:   res_nxt = lo_nxt;
      2'b01:   res_nxt = acc_nxt[WIDTH-1:0];
      2'b10:   res_nxt = lo_nxt;
      default: res_nxt = acc_nxt[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      acc      <= '0;
      lo       <= '0;
      opr      <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          dz_q   <= 1'b0;
          if (accept) begin
            op  <= bus.funct;
            cnt <= '0;
            acc <= '0;
            if (!bus.funct[1]) begin
              lo    <= bus.b;
              opr   <= bus.a;
              state <= RUN;
            end else begin
              lo  <= bus.a;
              opr <= bus.b;
              if (bus.b == '0) begin
                // Divide by zero skips the loop entirely.
                state    <= DONE;
                done_q   <= 1'b1;
                dz_q     <= 1'b1;
                result_q <= bus.funct[0] ? bus.a : '1;
              end else begin
                state <= RUN;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= res_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_muldiv_seq.sv
module tb_exec_muldiv_seq;
  localparam int W = 16;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  int         n_vec;
  int         n_bad;
  logic [W:0] exp_q[$];

  exec_muldiv_seq_if #(.WIDTH(W)) bus ();

  exec_muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {dz_err, result}
  function automatic logic [W:0] model(input logic [1:0] f, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (f)
      2'b00:   return {1'b0, p[W-1:0]};
      2'b01:   return {1'b0, p[2*W-1:W]};
      2'b10:   return (b == 0) ? {1'b1, {W{1'b1}}} : {1'b0, a / b};
      default: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        check("result", 32'({bus.dz_err, bus.result}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge where done is seen, start still high.
  task automatic run_op(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat);
    int lat;
    exp_q.push_back(model(f, a, b));
    bus.funct = f;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    #1;
    check("stall_accept", 32'(bus.stall), 32'd1);
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) break;
      check("stall_run", 32'(bus.stall), 32'd1);
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic drop_start();
    bus.start = 1'b0;
    #1;
    check("stall_done_idle", 32'(bus.stall), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   f;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_dz", 32'(bus.dz_err), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b00, 16'd3, 16'd5, 17);           drop_start();
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 17);     drop_start();
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 17);     drop_start();
    run_op(2'b10, 16'd100, 16'd7, 17);         drop_start();
    run_op(2'b11, 16'd100, 16'd7, 17);         drop_start();
    run_op(2'b11, 16'h8000, 16'h8000, 17);     drop_start();
    run_op(2'b10, 16'h1234, 16'h0000, 1);      drop_start();
    run_op(2'b11, 16'h1234, 16'h0000, 1);      drop_start();

    // Back-to-back: second op accepted in the DONE cycle of the first.
    run_op(2'b10, 16'd9, 16'd3, 17);
    run_op(2'b00, 16'd2, 16'd2, 17);
    drop_start();

    // Flush during RUN at cnt==8: no done, result keeps 0x0004.
    bus.funct = 2'b00;
    bus.a     = 16'd7;
    bus.b     = 16'd7;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (9) @(negedge clk);
    check("flush_pre_state", 32'(fsm_state), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_state", 32'(fsm_state), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_stall", 32'(bus.stall), 32'd0);
    check("flush_result", 32'(bus.result), 32'h0004);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("flush_result_hold", 32'(bus.result), 32'h0004);

    // Asynchronous reset in the middle of an operation (cnt==5).
    bus.funct = 2'b00;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (6) @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    #1;
    check("arst_result", 32'(bus.result), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_dz", 32'(bus.dz_err), 32'd0);
    check("arst_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random operations, occasionally with a zero divisor.
    for (int i = 0; i < 12; i++) begin
      f  = 2'($urandom_range(0, 3));
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 16'hFFFF));
      run_op(f, ra, rb, (f[1] && rb == 0) ? 1 : 17);
      drop_start();
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
